// File: rtl/sample_window_sequencer.sv
// -----------------------------------------------------------------------------
// sample_window_sequencer
//
// Sequences one capture window of a signal_flatener instance:
//   1. on an accepted start, pulse flat_clear for one cycle,
//   2. issue exactly NUM_OF_SAMPLES flat_we strobes spaced P cycles apart,
//      where P is the period latched at start (0 is treated as 1),
//   3. hold the completed frame behind out_valid/out_ready,
//   4. pulse done for one cycle after the handshake and return to IDLE.
// abort terminates any active window without a done pulse. A start seen
// outside IDLE is dropped and recorded in the sticky overrun flag.
//
// Every output is a flop. The combinational block therefore computes the
// value each output must show in the *next* cycle, and the strobe decision
// is made one cycle ahead of the cycle in which flat_we is visible.
//
// Parameters
//   NUM_OF_SAMPLES  strobes per window (>= 1); must match the flattener
//   PERIOD_WIDTH    width of the sample-spacing input
//   IDX_WIDTH       width of sample_idx (derived, leave at default)
//
// Ports
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   start       in   window request, accepted only in IDLE
//   abort       in   terminates an active window
//   period      in   cycles between strobes, latched on accepted start
//   out_ready   in   downstream accepts the held frame
//   flat_clear  out  one-cycle clear pulse to the flattener
//   flat_we     out  one-cycle write strobe to the flattener
//   sample_idx  out  index of the current/last strobe
//   busy        out  high in every state except IDLE
//   out_valid   out  frame complete and held
//   done        out  one-cycle pulse after a successful handshake
//   overrun     out  sticky: start seen while not IDLE
// -----------------------------------------------------------------------------
module sample_window_sequencer #(
  parameter int NUM_OF_SAMPLES = 4,
  parameter int PERIOD_WIDTH   = 16,
  parameter int IDX_WIDTH      = (NUM_OF_SAMPLES > 1) ? $clog2(NUM_OF_SAMPLES) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    out_ready,
  output logic                    flat_clear,
  output logic                    flat_we,
  output logic [IDX_WIDTH-1:0]    sample_idx,
  output logic                    busy,
  output logic                    out_valid,
  output logic                    done,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [IDX_WIDTH-1:0]    LAST_IDX = IDX_WIDTH'(NUM_OF_SAMPLES - 1);
  localparam logic [IDX_WIDTH-1:0]    IDX_ONE  = IDX_WIDTH'(1);
  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE  = PERIOD_WIDTH'(1);

  // Registered state
  state_t                  state;
  logic [PERIOD_WIDTH-1:0] period_q;     // spacing latched for this window
  logic [PERIOD_WIDTH-1:0] spacing_cnt;  // cycles until the next strobe is registered

  // Next-cycle values
  state_t                  state_d;
  logic [PERIOD_WIDTH-1:0] period_d;
  logic [PERIOD_WIDTH-1:0] spacing_cnt_d;
  logic                    flat_clear_d;
  logic                    flat_we_d;
  logic [IDX_WIDTH-1:0]    sample_idx_d;
  logic                    busy_d;
  logic                    out_valid_d;
  logic                    done_d;
  logic                    overrun_d;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that leaves
    // one unassigned would infer a latch.
    state_d       = state;
    period_d      = period_q;
    spacing_cnt_d = spacing_cnt;
    flat_clear_d  = 1'b0;
    flat_we_d     = 1'b0;
    sample_idx_d  = sample_idx;
    out_valid_d   = 1'b0;
    done_d        = 1'b0;
    overrun_d     = overrun;

    // A request that cannot be honoured is remembered, whatever else happens.
    if (start && (state != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        // abort in the same cycle as start suppresses the request.
        if (start && !abort) begin
          period_d     = (period == '0) ? CNT_ONE : period;
          overrun_d    = 1'b0;
          sample_idx_d = '0;
          flat_clear_d = 1'b1;
          state_d      = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        // The first strobe follows the clear pulse directly; the counter is
        // then loaded so the next strobe lands P cycles after this one.
        flat_we_d     = 1'b1;
        spacing_cnt_d = period_q;
        state_d       = ST_SAMPLE;
      end

      ST_SAMPLE: begin
        if (flat_we && (sample_idx == LAST_IDX)) begin
          // The final strobe is visible now: the frame is complete.
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          // The index advances right after each visible strobe.
          if (flat_we) begin
            sample_idx_d = sample_idx + IDX_ONE;
          end
          // Counter saturates at 1 rather than wrapping through zero.
          if (spacing_cnt <= CNT_ONE) begin
            flat_we_d     = 1'b1;
            spacing_cnt_d = period_q;
          end else begin
            spacing_cnt_d = spacing_cnt - CNT_ONE;
          end
        end
      end

      ST_HOLD: begin
        // out_valid is high throughout HOLD, so out_ready alone completes
        // the handshake here.
        if (out_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // abort outranks a pending strobe, a clear and the handshake.
    if (abort && (state != ST_IDLE)) begin
      state_d      = ST_IDLE;
      flat_clear_d = 1'b0;
      flat_we_d    = 1'b0;
      out_valid_d  = 1'b0;
      done_d       = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      period_q    <= CNT_ONE;
      spacing_cnt <= CNT_ONE;
      flat_clear  <= 1'b0;
      flat_we     <= 1'b0;
      sample_idx  <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_d;
      period_q    <= period_d;
      spacing_cnt <= spacing_cnt_d;
      flat_clear  <= flat_clear_d;
      flat_we     <= flat_we_d;
      sample_idx  <= sample_idx_d;
      busy        <= busy_d;
      out_valid   <= out_valid_d;
      done        <= done_d;
      overrun     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_sample_window_sequencer.sv
// -----------------------------------------------------------------------------
// Directed testbench for sample_window_sequencer (NUM_OF_SAMPLES = 4).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on
// the rising edge. "Cycle c" of a window is the c-th cycle after the edge
// that accepted start, so cycle 1 carries flat_clear and cycle 2 the first
// strobe.
// -----------------------------------------------------------------------------
module tb_sample_window_sequencer;

  localparam int NS = 4;
  localparam int PW = 16;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [PW-1:0] period;
  logic          out_ready;
  logic          flat_clear;
  logic          flat_we;
  logic [IW-1:0] sample_idx;
  logic          busy;
  logic          out_valid;
  logic          done;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sample_window_sequencer #(
    .NUM_OF_SAMPLES (NS),
    .PERIOD_WIDTH   (PW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .period     (period),
    .out_ready  (out_ready),
    .flat_clear (flat_clear),
    .flat_we    (flat_we),
    .sample_idx (sample_idx),
    .busy       (busy),
    .out_valid  (out_valid),
    .done       (done),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // idx < 0 skips the sample_idx comparison.
  task automatic expect_out(input string tag, input logic clr, input logic we, input int idx,
                            input logic bz, input logic vl, input logic dn, input logic ov);
    check({tag, ".flat_clear"}, 32'(flat_clear), 32'(clr));
    check({tag, ".flat_we"},    32'(flat_we),    32'(we));
    if (idx >= 0) check({tag, ".sample_idx"}, 32'(sample_idx), 32'(idx));
    check({tag, ".busy"},       32'(busy),       32'(bz));
    check({tag, ".out_valid"},  32'(out_valid),  32'(vl));
    check({tag, ".done"},       32'(done),       32'(dn));
    check({tag, ".overrun"},    32'(overrun),    32'(ov));
  endtask

  // Entered in cycle 1 of a window with effective spacing p. Checks cycles
  // 1..stop (stop = 0 means up to the first out_valid cycle). Optionally
  // pulses start during cycle pulse_at and changes period during chg_at.
  task automatic check_window(input string tag, input int p, input int stop_at,
                              input int pulse_at, input int chg_at, input logic [PW-1:0] chg_val);
    int last_full;
    int stop;
    last_full = 3 + (NS - 1) * p;
    stop      = (stop_at > 0) ? stop_at : last_full;
    start     = 1'b0;
    for (int c = 1; c <= stop; c++) begin
      logic e_we;
      int   e_idx;
      int   k;
      e_we  = (c >= 2) && (((c - 2) % p) == 0) && (((c - 2) / p) <= NS - 1);
      k     = (c <= 2) ? 0 : (c - 2 + p - 1) / p;
      e_idx = (k > NS - 1) ? NS - 1 : k;
      expect_out($sformatf("%s.c%0d", tag, c), c == 1, e_we, e_idx, 1'b1,
                 c >= last_full, 1'b0, (pulse_at > 0) && (c > pulse_at));
      if (c < stop) begin
        start = (c == pulse_at);
        if (c == chg_at) period = chg_val;
        tick();
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    period    = '0;

    // Reset state
    tick();
    tick();
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    expect_out("idle", 0, 0, 0, 0, 0, 0, 0);

    // period=3, out_ready tied high: clear at 1, strobes at 2,5,8,11,
    // out_valid at 12, done at 13.
    out_ready = 1'b1;
    period    = 16'd3;
    start     = 1'b1;
    tick();
    check_window("p3", 3, 0, 0, 0, '0);
    tick();
    expect_out("p3.done", 0, 0, 3, 0, 0, 1, 0);
    tick();
    expect_out("p3.after", 0, 0, 3, 0, 0, 0, 0);

    // period=0 behaves as period=1: four back-to-back strobes.
    period = 16'd0;
    start  = 1'b1;
    tick();
    check_window("p0", 1, 0, 0, 0, '0);
    tick();
    expect_out("p0.done", 0, 0, 3, 0, 0, 1, 0);
    tick();

    // Downstream stalls for 50 cycles; frame is held with no further strobes.
    out_ready = 1'b0;
    period    = 16'd2;
    start     = 1'b1;
    tick();
    check_window("hold", 2, 0, 0, 0, '0);
    for (int i = 0; i < 50; i++) begin
      tick();
      expect_out($sformatf("hold.stall%0d", i), 0, 0, 3, 1, 1, 0, 0);
    end
    out_ready = 1'b1;
    tick();
    expect_out("hold.done", 0, 0, 3, 0, 0, 1, 0);
    tick();
    expect_out("hold.after", 0, 0, 3, 0, 0, 0, 0);

    // start together with abort in IDLE: start is ignored.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    expect_out("idle_abort", 0, 0, 3, 0, 0, 0, 0);

    // abort while the 3rd strobe (cycle 6, p=2) is pending.
    period = 16'd2;
    start  = 1'b1;
    tick();
    check_window("abort", 2, 5, 0, 0, '0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_out("abort.c6", 0, 0, -1, 0, 0, 0, 0);
    tick();
    expect_out("abort.c7", 0, 0, -1, 0, 0, 0, 0);
    tick();
    expect_out("abort.c8", 0, 0, -1, 0, 0, 0, 0);

    // Full window after the abort, beginning with flat_clear.
    period = 16'd1;
    start  = 1'b1;
    tick();
    check_window("post_abort", 1, 0, 0, 0, '0);
    tick();
    expect_out("post_abort.done", 0, 0, 3, 0, 0, 1, 0);
    tick();

    // start during SAMPLE sets overrun without disturbing the window timing.
    period = 16'd2;
    start  = 1'b1;
    tick();
    check_window("ovr", 2, 0, 4, 0, '0);
    tick();
    expect_out("ovr.done", 0, 0, 3, 0, 0, 1, 1);

    // start in the done cycle is accepted and clears overrun; period is
    // changed mid-window and another start lands in SAMPLE.
    start     = 1'b1;
    period    = 16'd3;
    out_ready = 1'b0;
    tick();
    check_window("restart", 3, 0, 6, 3, 16'd9);
    tick();
    expect_out("restart.hold", 0, 0, 3, 1, 1, 0, 1);

    // reset in HOLD with overrun set returns everything to reset values.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("reset_hold", 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_out("reset_hold.after", 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
